// File: rtl/mesh_gnrtr_pkg.sv
// mesh_gnrtr_pkg: packet field widths and terminal-ID/coordinate helpers for the mesh generator.
package mesh_gnrtr_pkg;

    localparam int NXT_W = 8;
    localparam int ROW_W = 4;
    localparam int COL_W = 4;

    function automatic int calc_drvs(int r, int c);
        return 2 * r + 2 * c;
    endfunction

    // Terminals sit one step outside the router grid: top, left, bottom, then right.
    function automatic int term_row(int id, int r, int c);
        return id < c ? 0 : id < c + r ? id - c + 1 : id < 2 * c + r ? r + 1 : id - 2 * c - r + 1;
    endfunction

    function automatic int term_col(int id, int r, int c);
        return id < c ? id + 1 : id < c + r ? 0 : id < 2 * c + r ? id - c - r + 1 : c + 1;
    endfunction

    function automatic int coord_to_id(int row, int col, int r, int c);
        if (row == 0 && col >= 1 && col <= c) return col - 1;
        if (col == 0 && row >= 1 && row <= r) return c + row - 1;
        if (row == r + 1 && col >= 1 && col <= c) return c + r + col - 1;
        if (col == c + 1 && row >= 1 && row <= r) return 2 * c + r + row - 1;
        return -1;
    endfunction

    // The last router before a terminal is the terminal coordinate clamped into the grid.
    function automatic logic [7:0] router_code(int id, int r, int c);
        int rr, cc;
        rr = term_row(id, r, c);
        cc = term_col(id, r, c);
        rr = rr < 1 ? 1 : rr > r ? r : rr;
        cc = cc < 1 ? 1 : cc > c ? c : cc;
        return {4'(rr), 4'(cc)};
    endfunction

endpackage

// File: rtl/mesh_gnrtr_vif.sv
// mesh_gnrtr_vif: signal bundle for driving and observing a mesh_gnrtr instance.
interface mesh_gnrtr_vif
    import mesh_gnrtr_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLUMS = 4,
    parameter int pckg_sz = 40,
    parameter int fifo_depth = 4,
    parameter logic [7:0] bdcst = 8'hFF,
    localparam int drvs = calc_drvs(ROWS, COLUMS)
) (
    input logic clk
);
    logic reset;
    logic [drvs-1:0][pckg_sz-1:0] data_out_i_in;
    logic [drvs-1:0] pndng_i_in;
    logic [drvs-1:0] popin;
    logic [drvs-1:0][pckg_sz-1:0] data_out;
    logic [drvs-1:0] pndng;
    logic [drvs-1:0] pop;
endinterface

// File: rtl/mesh_out_fifo.sv
// mesh_out_fifo: per-terminal output FIFO; head word is zero while empty.
module mesh_out_fifo #(
    parameter int W = 40,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         pndng,
    output logic         full
);
    localparam int AW = D > 1 ? $clog2(D) : 1;
    localparam int CW = $clog2(D + 1);

    logic [W-1:0] mem [D];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic do_push, do_pop;

    function automatic logic [AW-1:0] inc(logic [AW-1:0] p);
        return p == AW'(D - 1) ? '0 : p + 1'b1;
    endfunction

    assign full    = cnt == CW'(D);
    assign pndng   = cnt != '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & pndng;
    assign dout    = pndng ? mem[rp] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= inc(wp);
            if (do_pop) rp <= inc(rp);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) if (do_push) mem[wp] <= din;

endmodule

// File: rtl/mesh_gnrtr.sv
// mesh_gnrtr: round-robin arbiter that routes one source packet per cycle into the
// output FIFO of its edge terminal (or all others on broadcast), stamping the last router.
module mesh_gnrtr
    import mesh_gnrtr_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLUMS = 4,
    parameter int pckg_sz = 40,
    parameter int fifo_depth = 4,
    parameter logic [7:0] bdcst = 8'hFF,
    localparam int drvs = calc_drvs(ROWS, COLUMS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [drvs-1:0][pckg_sz-1:0] data_out_i_in,
    input  logic [drvs-1:0]               pndng_i_in,
    output logic [drvs-1:0]               popin,
    output logic [drvs-1:0][pckg_sz-1:0] data_out,
    output logic [drvs-1:0]               pndng,
    input  logic [drvs-1:0]               pop
);
    localparam int IW = $clog2(drvs);
    localparam int LW = pckg_sz - NXT_W;
    localparam logic [drvs-1:0] ONE = drvs'(1);
    localparam logic [pckg_sz-1:0] LOW_MASK = {{NXT_W{1'b0}}, {LW{1'b1}}};

    logic [drvs-1:0] full, elig, bc, dv, wr;
    logic [IW-1:0] dst [drvs];
    logic [IW-1:0] ptr, g;
    logic gv, gr;
    logic [pckg_sz-1:0] sel;

    function automatic logic [IW-1:0] nxt_idx(logic [IW-1:0] p, int k);
        return IW'((int'(p) + k) % drvs);
    endfunction

    for (genvar i = 0; i < drvs; i++) begin : g_in
        int d;
        assign d = coord_to_id(int'(data_out_i_in[i][pckg_sz-9 -: ROW_W]),
                               int'(data_out_i_in[i][pckg_sz-13 -: COL_W]), ROWS, COLUMS);
        assign bc[i]   = data_out_i_in[i][pckg_sz-9 -: ROW_W+COL_W] == bdcst;
        assign dv[i]   = d >= 0;
        assign dst[i]  = IW'(d);
        // Undeliverable destinations are always eligible so they get popped and dropped.
        assign elig[i] = pndng_i_in[i] & (bc[i] ? ~|(full & ~(ONE << i)) : ~dv[i] | ~full[dst[i]]);
    end

    always_comb begin
        gv = 1'b0;
        g  = '0;
        for (int k = 0; k < drvs; k++) begin
            if (!gv && elig[nxt_idx(ptr, k)]) begin
                gv = 1'b1;
                g  = nxt_idx(ptr, k);
            end
        end
    end

    assign gr    = gv & ~reset;
    assign popin = gr ? ONE << g : '0;
    assign sel   = data_out_i_in[g];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ptr <= '0;
        else if (gr) ptr <= nxt_idx(g, 1);
    end

    for (genvar j = 0; j < drvs; j++) begin : g_out
        assign wr[j] = gr & (bc[g] ? g != IW'(j) : dv[g] & (dst[g] == IW'(j)));
        mesh_out_fifo #(.W(pckg_sz), .D(fifo_depth)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (wr[j]),
            .din   ({router_code(j, ROWS, COLUMS), LW'(0)} | (sel & LOW_MASK)),
            .pop   (pop[j]),
            .dout  (data_out[j]),
            .pndng (pndng[j]),
            .full  (full[j])
        );
    end

endmodule

// File: tb/tb_mesh_gnrtr.sv
// tb_mesh_gnrtr: directed and randomized checks of mesh_gnrtr against a queue-based model.
module tb_mesh_gnrtr;
    localparam int N = 16;
    localparam int PW = 40;
    localparam int DEP = 4;
    localparam int AW = N * PW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    mesh_gnrtr_vif vif (.clk(clk));

    mesh_gnrtr dut (
        .clk           (clk),
        .reset         (vif.reset),
        .data_out_i_in (vif.data_out_i_in),
        .pndng_i_in    (vif.pndng_i_in),
        .popin         (vif.popin),
        .data_out      (vif.data_out),
        .pndng         (vif.pndng),
        .pop           (vif.pop)
    );

    int checks = 0;
    int failures = 0;
    int tr[N], tc[N];
    logic [7:0] nxt[N];
    logic [PW-1:0] q[N][$];
    int mp;
    int grants[$];
    logic [PW-1:0] p;

    task automatic chk(string tag, logic [AW-1:0] got, logic [AW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] mk(logic [3:0] r, logic [3:0] c, logic m, logic [22:0] pl);
        return {8'h00, r, c, m, pl};
    endfunction

    function automatic int dest(logic [PW-1:0] pk);
        if (pk[31:24] == 8'hFF) return -2;
        for (int t = 0; t < N; t++)
            if (tr[t] == int'(pk[31:28]) && tc[t] == int'(pk[27:24])) return t;
        return -1;
    endfunction

    function automatic bit accepts(int i);
        int d;
        d = dest(vif.data_out_i_in[i]);
        if (d == -1) return 1'b1;
        if (d == -2) begin
            for (int j = 0; j < N; j++) if (j != i && q[j].size() >= DEP) return 1'b0;
            return 1'b1;
        end
        return q[d].size() < DEP;
    endfunction

    function automatic logic [PW-1:0] rand_pkt();
        int s, t;
        logic [3:0] r, c;
        s = $urandom_range(0, 19);
        t = $urandom_range(0, N - 1);
        r = 4'(tr[t]);
        c = 4'(tc[t]);
        if (s == 14) begin
            r = 4'hF;
            c = 4'hF;
        end else if (s > 14) begin
            r = 4'($urandom);
            c = 4'($urandom);
        end
        return {8'($urandom), r, c, 1'($urandom), 23'($urandom)};
    endfunction

    // Checks the DUT at the falling edge, then advances the model over the next rising edge.
    task automatic step();
        int eg, d;
        logic [N-1:0] ep, epn, seen;
        logic [N-1:0][PW-1:0] ed;
        logic [PW-1:0] pk;
        @(negedge clk);
        eg = -1;
        if (vif.reset) begin
            for (int j = 0; j < N; j++) q[j].delete();
            mp = 0;
        end else begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (mp + k) % N;
                if (eg < 0 && vif.pndng_i_in[i] && accepts(i)) eg = i;
            end
        end
        ep = '0;
        if (eg >= 0) ep[eg] = 1'b1;
        for (int j = 0; j < N; j++) begin
            epn[j] = q[j].size() > 0;
            ed[j] = epn[j] ? q[j][0] : '0;
        end
        chk("popin", AW'(vif.popin), AW'(ep));
        chk("pndng", AW'(vif.pndng), AW'(epn));
        chk("data_out", vif.data_out, ed);
        seen = vif.popin;
        pk = vif.data_out_i_in[eg < 0 ? 0 : eg];
        for (int j = 0; j < N; j++) if (vif.pop[j] && q[j].size() > 0) void'(q[j].pop_front());
        if (eg >= 0) begin
            grants.push_back(eg);
            d = dest(pk);
            for (int j = 0; j < N; j++)
                if (d == -2 ? j != eg : d == j) q[j].push_back({nxt[j], pk[31:0]});
            mp = (eg + 1) % N;
        end
        @(posedge clk);
        #1;
        vif.pndng_i_in = vif.pndng_i_in & ~seen;
    endtask

    task automatic do_reset();
        vif.reset = 1'b1;
        step();
        vif.reset = 1'b0;
        grants.delete();
    endtask

    task automatic drain();
        vif.pop = '1;
        repeat (DEP + 1) step();
        vif.pop = '0;
    endtask

    initial begin
        for (int t = 0; t < N; t++) begin
            tr[t] = t < 4 ? 0 : t < 8 ? t - 3 : t < 12 ? 5 : t - 11;
            tc[t] = t < 4 ? t + 1 : t < 8 ? 0 : t < 12 ? t - 7 : 5;
            nxt[t] = {4'(tr[t] < 1 ? 1 : tr[t] > 4 ? 4 : tr[t]), 4'(tc[t] < 1 ? 1 : tc[t] > 4 ? 4 : tc[t])};
        end
        mp = 0;
        vif.reset = 1'b1;
        vif.pndng_i_in = '0;
        vif.data_out_i_in = '0;
        vif.pop = '0;
        step();
        step();
        chk("rst_pndng", AW'(vif.pndng), '0);
        chk("rst_popin", AW'(vif.popin), '0);
        vif.reset = 1'b0;

        // single unicast to the right edge, row 1
        p = mk(4'd1, 4'd5, 1'b1, 23'b10101);
        vif.data_out_i_in[1] = p;
        vif.pndng_i_in[1] = 1'b1;
        step();
        chk("r35_grant", AW'(grants.size()), AW'(1));
        chk("r35_pndng", AW'(vif.pndng), AW'(16'h1000));
        chk("r35_data", AW'(vif.data_out[12]), AW'({8'h14, p[31:0]}));
        step();
        vif.pop[12] = 1'b1;
        step();
        vif.pop = '0;
        chk("r35_empty", AW'(vif.pndng), '0);

        // three contenders for the same sink
        do_reset();
        vif.data_out_i_in[0] = mk(4'd1, 4'd5, 1'b0, 23'd1);
        vif.data_out_i_in[4] = mk(4'd1, 4'd5, 1'b0, 23'd2);
        vif.data_out_i_in[8] = mk(4'd1, 4'd5, 1'b0, 23'd3);
        vif.pndng_i_in = 16'h0111;
        repeat (3) step();
        chk("r36_g0", AW'(grants[0]), AW'(0));
        chk("r36_g1", AW'(grants[1]), AW'(4));
        chk("r36_g2", AW'(grants[2]), AW'(8));
        chk("r36_o0", AW'(vif.data_out[12][22:0]), AW'(1));
        vif.pop[12] = 1'b1;
        step();
        chk("r36_o1", AW'(vif.data_out[12][22:0]), AW'(2));
        step();
        chk("r36_o2", AW'(vif.data_out[12][22:0]), AW'(3));
        step();
        vif.pop = '0;

        // sink full: fifth packet waits until a pop frees a slot
        do_reset();
        for (int i = 0; i < 5; i++) vif.data_out_i_in[i] = mk(4'd1, 4'd5, 1'b0, 23'(i + 10));
        vif.pndng_i_in = 16'h001F;
        repeat (5) step();
        chk("r37_wait", AW'(vif.popin), '0);
        chk("r37_cnt4", AW'(grants.size()), AW'(4));
        vif.pop[12] = 1'b1;
        step();
        vif.pop = '0;
        step();
        chk("r37_cnt5", AW'(grants.size()), AW'(5));
        drain();

        // broadcast from terminal 0
        do_reset();
        vif.data_out_i_in[0] = mk(4'hF, 4'hF, 1'b1, 23'd77);
        vif.pndng_i_in[0] = 1'b1;
        step();
        chk("r38_pndng", AW'(vif.pndng), AW'(16'hFFFE));
        chk("r38_nxt5", AW'(vif.data_out[5][39:32]), AW'(8'h21));
        drain();

        // interior destination is dropped
        vif.data_out_i_in[2] = mk(4'd2, 4'd2, 1'b0, 23'd5);
        vif.pndng_i_in[2] = 1'b1;
        step();
        chk("r39_grant", AW'(grants[$]), AW'(2));
        step();
        chk("r39_none", AW'(vif.pndng), '0);

        repeat (400) begin
            for (int i = 0; i < N; i++)
                if (!vif.pndng_i_in[i] && $urandom_range(0, 3) == 0) begin
                    vif.data_out_i_in[i] = rand_pkt();
                    vif.pndng_i_in[i] = 1'b1;
                end
            vif.pop = 16'($urandom);
            step();
        end
        vif.pndng_i_in = '0;
        drain();

        // asynchronous reset while data is buffered
        vif.data_out_i_in[1] = p;
        vif.pndng_i_in[1] = 1'b1;
        step();
        step();
        chk("r40_pre", AW'(vif.pndng[12]), AW'(1));
        #2;
        vif.reset = 1'b1;
        vif.pndng_i_in[1] = 1'b1;
        #1;
        chk("r40_pndng", AW'(vif.pndng), '0);
        chk("r40_data", vif.data_out, '0);
        chk("r40_popin", AW'(vif.popin), '0);
        step();
        vif.reset = 1'b0;
        vif.pndng_i_in = '0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
